// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control with branch, stall and halt handling.
// Define RET_STACK_EN to add the 4-entry return-address stack used by call/ret.
module pc_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       br_taken,
    input  logic [9:0] br_target,
    input  logic       call,
    input  logic       ret,
    input  logic       halt,
    input  logic       resume,
    output logic [9:0] pc,
    output logic       pc_valid,
    output logic       halted,
    output logic       stack_err
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t     state_q, state_d;
    logic [9:0] pc_q, pc_d, pc_inc;
    logic       advance;

    assign pc_inc  = pc_q + 10'd1;
    assign advance = (state_q == RUN) && !halt && !stall;
    assign pc      = pc_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt) state_d = HALT;
            HALT:    if (resume) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        pc_valid = (state_q == RUN);
        halted   = (state_q == HALT);
    end

`ifdef RET_STACK_EN
    logic [3:0][9:0] stk_q, stk_d;
    logic [2:0]      sp_q, sp_d;
    logic            err_q, err_d;

    always_comb begin
        pc_d  = pc_q;
        stk_d = stk_q;
        sp_d  = sp_q;
        err_d = err_q;
        if (advance) begin
            if (call && ret) begin
                pc_d  = pc_inc;
                err_d = 1'b1;
            end else if (ret) begin
                if (sp_q == 3'd0) begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end else begin
                    pc_d = stk_q[sp_q[1:0] - 2'd1];
                    sp_d = sp_q - 3'd1;
                end
            end else if (call) begin
                // A full stack still takes the jump; only the push is lost.
                pc_d = br_target;
                if (sp_q == 3'd4) begin
                    err_d = 1'b1;
                end else begin
                    stk_d[sp_q[1:0]] = pc_inc;
                    sp_d             = sp_q + 3'd1;
                end
            end else if (br_taken) begin
                pc_d = br_target;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            stk_q <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            stk_q <= stk_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    assign stack_err = err_q;
`else
    // Without the stack, a lone call/ret is transparent; call+ret together just increments.
    always_comb begin
        pc_d = pc_q;
        if (advance) begin
            if (call && ret)   pc_d = pc_inc;
            else if (br_taken) pc_d = br_target;
            else               pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= '0;
        else     pc_q <= pc_d;
    end

    assign stack_err = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_pc_sequencer;
    logic       clk = 1'b0;
    logic       rst, stall, br_taken, call, ret, halt, resume;
    logic [9:0] br_target;
    logic [9:0] pc;
    logic       pc_valid, halted, stack_err;

    int n_chk  = 0;
    int n_fail = 0;

    // model: 0 = BOOT, 1 = RUN, 2 = HALT
    int m_state;
    int m_pc;
    bit m_err;
    int m_stk[$];

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .call(call), .ret(ret), .halt(halt), .resume(resume),
        .pc(pc), .pc_valid(pc_valid), .halted(halted), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit st, input bit br, input int tgt,
                         input bit ca, input bit re, input bit ha, input bit rs);
        rst = r; stall = st; br_taken = br; br_target = tgt[9:0];
        call = ca; ret = re; halt = ha; resume = rs;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_step();
        if (rst) begin
            m_state = 0; m_pc = 0; m_err = 0; m_stk.delete();
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 2) begin
            if (resume) m_state = 1;
        end else if (halt) begin
            m_state = 2;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (call && ret) begin
            m_pc = (m_pc + 1) % 1024;
`ifdef RET_STACK_EN
            m_err = 1;
`endif
        end
`ifdef RET_STACK_EN
        else if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = (m_pc + 1) % 1024; m_err = 1; end
        end else if (call) begin
            if (m_stk.size() < 4) m_stk.push_back((m_pc + 1) % 1024);
            else m_err = 1;
            m_pc = br_target;
        end
`endif
        else if (br_taken) begin
            m_pc = br_target;
        end else begin
            m_pc = (m_pc + 1) % 1024;
        end
    endtask

    // One clock: model advances on the same inputs, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("pc", pc, m_pc);
        chk("pc_valid", pc_valid, m_state == 1);
        chk("halted", halted, m_state == 2);
        chk("stack_err", stack_err, m_err);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
    endtask

    task automatic goto_pc(input int tgt);
        drive(0, 0, 1, tgt, 0, 0, 0, 0);
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        m_state = 0; m_pc = 0; m_err = 0;

        // reset, boot, then counting from 0
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_valid", pc_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", stack_err, 0);
        tick();
        chk("boot_exit_pc", pc, 0);
        chk("boot_exit_valid", pc_valid, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("count_pc", pc, i);
        end

        // wrap 1023 -> 0
        goto_pc(1023);
        chk("at_1023", pc, 1023);
        tick();
        chk("wrap_pc", pc, 0);
        chk("wrap_err", stack_err, 0);

        // branch vs stalled branch
        goto_pc(50);
        drive(0, 0, 1, 106, 0, 0, 0, 0);
        tick();
        chk("branch_pc", pc, 106);
        goto_pc(50);
        drive(0, 1, 1, 106, 0, 0, 0, 0);
        tick();
        chk("stall_branch_pc", pc, 50);
        idle();

        // halt with branch noise, then resume
        goto_pc(10);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        chk("halt_flag", halted, 1);
        chk("halt_pc", pc, 10);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 300, 1, 0, 1, 0);
            tick();
            chk("halt_hold_pc", pc, 10);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("resume_pc", pc, 10);
        chk("resume_valid", pc_valid, 1);
        idle();
        tick();
        chk("resume_next_pc", pc, 11);

`ifdef RET_STACK_EN
        // fill the stack, overflow, then unwind and underflow
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            int src;
            src = (i == 0) ? 5 : 10 * (i + 1);
            goto_pc(src);
            drive(0, 0, 0, 100, 1, 0, 0, 0);
            tick();
            chk("call_pc", pc, 100);
        end
        chk("four_calls_err", stack_err, 0);
        drive(0, 0, 0, 100, 1, 0, 0, 0);
        tick();
        chk("overflow_err", stack_err, 1);
        chk("overflow_pc", pc, 100);
        for (int i = 0; i < 4; i++) begin
            int exp_ret;
            exp_ret = (i == 3) ? 6 : 41 - 10 * i;
            drive(0, 0, 0, 0, 0, 1, 0, 0);
            tick();
            chk("ret_pc", pc, exp_ret);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        chk("underflow_pc", pc, 7);
        chk("underflow_err", stack_err, 1);
        // conflict: call+ret increments
        drive(0, 0, 0, 200, 1, 1, 0, 0);
        tick();
        chk("conflict_pc", pc, 8);
        // push one entry so reset must clear it
        drive(0, 0, 0, 300, 1, 0, 0, 0);
        tick();
`endif

        // reset from HALT with whatever error state exists
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        chk("pre_rst_halted", halted, 1);
        do_reset();
        chk("halt_rst_pc", pc, 0);
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_err", stack_err, 0);
        tick();
`ifdef RET_STACK_EN
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        chk("rst_stack_empty_err", stack_err, 1);
        chk("rst_stack_empty_pc", pc, 1);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int tgt;
            tgt = ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 1023));
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0, tgt,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
